// File: rtl/vga_if.sv
// ============================================================================
// Module      : vga_if
// Description : VGA pixel stream bundle (timing counters, syncs, blanks, rgb).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

`default_nettype wire

// File: rtl/projectile_cat.sv
// ============================================================================
// Module      : projectile_cat
// Description : Launches a projectile on space release, integrates a per-frame
//               ballistic trajectory, overlays it on VGA and reports landing x.
//               Overlay drawing is enabled by defining PROJECTILE_DRAW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module projectile_cat #(
    parameter int X_START   = 20,
    parameter int Y_START   = 380,
    parameter int GROUND_Y  = 440,
    parameter int X_LIMIT   = 780,
    parameter int GRAVITY   = 1,
    parameter int PROJ_SIZE = 8,
    parameter int PROJ_RGB  = 12'hFF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       space,
    input  logic [9:0] throw_force,
    vga_if.slave       vga_in,
    vga_if.master      vga_out,
    output logic       busy,
    output logic       landed,
    output logic [9:0] land_x
);

    localparam logic        [10:0] c_X_START  = 11'(X_START);
    localparam logic        [10:0] c_X_LIMIT  = 11'(X_LIMIT);
    localparam logic signed [11:0] c_Y_START  = 12'(Y_START);
    localparam logic signed [11:0] c_GROUND_Y = 12'(GROUND_Y);
    localparam logic signed [11:0] c_GRAVITY  = 12'(GRAVITY);
    localparam logic        [11:0] c_SIZE_X   = 12'(PROJ_SIZE);
    localparam logic signed [12:0] c_SIZE_Y   = 13'(PROJ_SIZE);
    localparam logic        [11:0] c_RGB      = 12'(PROJ_RGB);
`ifdef PROJECTILE_DRAW_EN
    localparam logic               c_DRAW_EN  = 1'b1;
`else
    localparam logic               c_DRAW_EN  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_FLIGHT = 2'd2,
        S_LANDED = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_space_prev;
    logic                r_vblnk_prev;
    logic         [10:0] r_x;
    logic signed  [11:0] r_y;
    logic         [4:0]  r_vx;
    logic signed  [11:0] r_vy;
    logic         [9:0]  r_land_x;

    logic                w_release;
    logic                w_tick;
    logic         [7:0]  w_f;
    logic         [4:0]  w_vx0;
    logic signed  [11:0] w_vy0;
    logic         [10:0] w_x_sum;
    logic signed  [11:0] w_y_sum;
    logic signed  [11:0] w_vy_sum;
    logic                w_hit_x;
    logic                w_hit_y;

    assign w_release = r_space_prev & ~space;
    assign w_tick    = vga_in.vblnk & ~r_vblnk_prev;

    // Saturate the charge at 128 so vx spans 0..16 and vy0 spans -32..0.
    assign w_f   = (throw_force > 10'd128) ? 8'd128 : throw_force[7:0];
    assign w_vx0 = w_f[7:3];
    assign w_vy0 = -$signed({6'b0, w_f[7:2]});

    assign w_x_sum  = r_x + {6'b0, r_vx};
    assign w_y_sum  = r_y + r_vy;
    assign w_vy_sum = r_vy + c_GRAVITY;
    assign w_hit_x  = (w_x_sum >= c_X_LIMIT);
    assign w_hit_y  = (w_y_sum >= c_GROUND_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_space_prev <= 1'b0;
            r_vblnk_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_space_prev <= space;
            r_vblnk_prev <= vga_in.vblnk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        landed      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_release) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                busy        = 1'b1;
                w_state_nxt = S_FLIGHT;
            end
            S_FLIGHT: begin
                busy = 1'b1;
                if (w_tick && (w_hit_x || w_hit_y)) w_state_nxt = S_LANDED;
            end
            S_LANDED: begin
                landed      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // land_x is loaded on the landing tick so it is already valid during the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= c_X_START;
            r_y      <= c_Y_START;
            r_vx     <= 5'd0;
            r_vy     <= 12'sd0;
            r_land_x <= 10'd0;
        end else if (r_state == S_ARM) begin
            r_x  <= c_X_START;
            r_y  <= c_Y_START;
            r_vx <= w_vx0;
            r_vy <= w_vy0;
        end else if (r_state == S_FLIGHT && w_tick) begin
            r_vy <= w_vy_sum;
            if (w_hit_x) begin
                r_x      <= c_X_LIMIT;
                r_y      <= w_y_sum;
                r_land_x <= c_X_LIMIT[9:0];
            end else if (w_hit_y) begin
                r_x      <= w_x_sum;
                r_y      <= c_GROUND_Y;
                r_land_x <= w_x_sum[9:0];
            end else begin
                r_x <= w_x_sum;
                r_y <= w_y_sum;
            end
        end
    end

    assign land_x = r_land_x;

    logic                w_on_x;
    logic                w_on_y;
    logic         [11:0] w_hc;
    logic         [11:0] w_x_end;
    logic signed  [12:0] w_vc;
    logic signed  [12:0] w_y_top;
    logic signed  [12:0] w_y_end;

    assign w_hc    = {1'b0, vga_in.hcount};
    assign w_x_end = {1'b0, r_x} + c_SIZE_X;
    assign w_on_x  = (w_hc >= {1'b0, r_x}) && (w_hc < w_x_end);

    // Vertical test is signed so a projectile above the screen never wraps onto it.
    assign w_vc    = $signed({2'b00, vga_in.vcount});
    assign w_y_top = {r_y[11], r_y};
    assign w_y_end = w_y_top + c_SIZE_Y;
    assign w_on_y  = (w_vc >= w_y_top) && (w_vc < w_y_end);

    assign vga_out.hcount = vga_in.hcount;
    assign vga_out.vcount = vga_in.vcount;
    assign vga_out.hsync  = vga_in.hsync;
    assign vga_out.vsync  = vga_in.vsync;
    assign vga_out.hblnk  = vga_in.hblnk;
    assign vga_out.vblnk  = vga_in.vblnk;
    assign vga_out.rgb    = (c_DRAW_EN && (r_state != S_IDLE) && w_on_x && w_on_y)
                            ? c_RGB : vga_in.rgb;

endmodule

`default_nettype wire

// File: tb/tb_projectile_cat.sv
// ============================================================================
// Module      : tb_projectile_cat
// Description : Randomised scoreboard bench for projectile_cat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_projectile_cat;

    logic       clk = 1'b0;
    logic       rst;
    logic       space;
    logic [9:0] throw_force;
    logic       busy;
    logic       landed;
    logic [9:0] land_x;

    vga_if vin ();
    vga_if vout ();

    projectile_cat dut (
        .clk         (clk),
        .rst         (rst),
        .space       (space),
        .throw_force (throw_force),
        .vga_in      (vin),
        .vga_out     (vout),
        .busy        (busy),
        .landed      (landed),
        .land_x      (land_x)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lx;
        int nt;
        int yf;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_cnt    = 0;
    logic prev_landed = 1'b0;

    task automatic check(input int act, input int exp, input string nm);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference trajectory: plain integer physics, frame by frame.
    task automatic model(input int force_in, output int lx, output int nt, output int yf);
        int f, x, y, vx, vy;
        f  = (force_in > 128) ? 128 : force_in;
        x  = 20;
        y  = 380;
        vx = f / 8;
        vy = -(f / 4);
        nt = 0;
        forever begin
            nt++;
            x  += vx;
            y  += vy;
            vy += 1;
            if (x >= 780) begin
                x = 780;
                break;
            end else if (y >= 440) begin
                y = 440;
                break;
            end
        end
        lx = x;
        yf = y;
    endtask

    function automatic bit pix_on(input int hc, input int vc, input int x, input int y);
        return (hc >= x) && (hc < x + 8) && (vc >= y) && (vc < y + 8);
    endfunction

    // Monitor: every landed pulse must match the oldest outstanding launch.
    always @(negedge clk) begin
        if (landed) begin
            if (prev_landed) begin
                check(1, 0, "landed_width");
            end else if (sb.size() == 0) begin
                check(1, 0, "unexpected_landed");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(int'(land_x), e.lx, "land_x");
                check(tick_cnt, e.nt, "land_tick");
                check(int'($signed(dut.r_y)), e.yf, "land_y");
                check(int'(busy), 0, "busy_at_landed");
            end
        end
        prev_landed = landed;
    end

    task automatic issue_tick();
        vin.vblnk = 1'b1;
        tick_cnt++;
        repeat (3) @(negedge clk);
        vin.vblnk = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic pixel_check(input int hc, input int vc, input int x, input int y);
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        bg         = 12'($urandom);
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.rgb    = bg;
        #1;
        exp_rgb = bg;
`ifdef PROJECTILE_DRAW_EN
        if (pix_on(hc, vc, x, y)) exp_rgb = 12'hFF0;
`endif
        check(int'(vout.rgb), int'(exp_rgb), "pixel_rgb");
        check(int'(vout.hcount), hc, "hcount_pass");
        check(int'(vout.vcount), vc, "vcount_pass");
    endtask

    task automatic launch(input int f);
        @(negedge clk);
        space       = 1'b1;
        throw_force = 10'($urandom);
        repeat (2) @(negedge clk);
        space       = 1'b0;
        throw_force = 10'(f);
        tick_cnt    = 0;
        @(negedge clk);
        check(int'(busy), 1, "busy_arm");
        @(negedge clk);
        throw_force = 10'($urandom);
    endtask

    task automatic throw(input int f, input bit toggle, input bit pix);
        int   lx, nt, yf, fs;
        exp_t e;
        model(f, lx, nt, yf);
        e.lx = lx;
        e.nt = nt;
        e.yf = yf;
        sb.push_back(e);
        fs = (f > 128) ? 128 : f;
        launch(f);
        for (int t = 0; t < 70 && busy; t++) begin
            issue_tick();
            if (pix && t == 0) begin
                pixel_check(30, 366, 20 + fs / 8, 380 - fs / 4);
                pixel_check(36, 366, 20 + fs / 8, 380 - fs / 4);
            end
            if (toggle && t == 2) begin
                space = 1'b1;
                repeat (2) @(negedge clk);
                space = 1'b0;
            end
        end
        check(int'(busy), 0, "flight_timeout");
        repeat (4) @(negedge clk);
        check(int'(busy), 0, "no_relaunch");
    endtask

    initial begin
        rst         = 1'b1;
        space       = 1'b0;
        throw_force = 10'd0;
        vin.hcount  = 11'd0;
        vin.vcount  = 11'd0;
        vin.hsync   = 1'b0;
        vin.vsync   = 1'b0;
        vin.hblnk   = 1'b0;
        vin.vblnk   = 1'b0;
        vin.rgb     = 12'd0;
        repeat (3) @(negedge clk);
        check(int'(busy), 0, "reset_busy");
        check(int'(landed), 0, "reset_landed");
        check(int'(land_x), 0, "reset_land_x");
        rst = 1'b0;

        vin.hsync = 1'b1;
        vin.hblnk = 1'b1;
        #1;
        check(int'(vout.hsync), 1, "hsync_pass");
        check(int'(vout.hblnk), 1, "hblnk_pass");
        check(int'(vout.vsync), 0, "vsync_pass");
        vin.hsync = 1'b0;
        vin.hblnk = 1'b0;

        throw(64, 1'b0, 1'b1);
        throw(0, 1'b0, 1'b0);
        throw(128, 1'b0, 1'b0);
        throw(1000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            throw(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b0);

        // Reset mid-flight must abort silently.
        launch(64);
        repeat (3) issue_tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check(int'(busy), 0, "abort_busy");
        check(int'(land_x), 0, "abort_land_x");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) issue_tick();
        check(int'(busy), 0, "abort_idle");

        throw(64, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check(sb.size(), 0, "scoreboard_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
